cu_microseq: RTL

Parametrised microcode sequencer that replaces the fixed two-phase control unit. It runs a variable number of micro-steps per instruction, up to 2^STEP_W, each step driven by an externally looked-up control word. It owns the program counter and the instruction register. It sits between program memory (instruction fetch), the microcode ROM sub-module, and the execution units (ALU etc.), which it drives through a start/done handshake.

---
 rtl/cu_pkg.sv | 21 ++
 rtl/cu_microrom.sv | 23 ++
 rtl/cu_microseq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the microcode sequencer: state encoding, control-word
// bit positions and default flag masks.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALTED = 3'd4
  } cu_state_e;

  localparam int FLAG_PCC  = 20;
  localparam int FLAG_HALT = 21;
  localparam int FLAG_END  = 22;

  // PCC + ROMO while fetching; AO..HO are the units that need a done handshake
  localparam logic [26:0] CU_FETCH_FLAGS = 27'h0110000;
  localparam logic [26:0] CU_WAIT_MASK   = 27'h00001FE;

endpackage

// File: rtl/cu_microrom.sv
// Two-level microcode ROM: uaddr selects a flag-table index, the index selects
// the control word. Contents are supplied by the integrator as flat parameters.
module cu_microrom #(
  parameter int IR_W   = 10,
  parameter int STEP_W = 2,
  parameter int FLAG_W = 27,
  parameter int IDX_W  = 4,
  parameter logic [(2**(IR_W+STEP_W))*IDX_W-1:0] INDEX_INIT = '0,
  parameter logic [(2**IDX_W)*FLAG_W-1:0]        FLAG_INIT  = '0
) (
  input  logic [IR_W+STEP_W-1:0] uaddr,
  output logic [FLAG_W-1:0]      uword
);

  logic [IDX_W-1:0] idx_s;

  // Combinational two-stage lookup so the word is valid in the same cycle
  always_comb begin
    idx_s = INDEX_INIT[int'(uaddr)*IDX_W +: IDX_W];
    uword = FLAG_INIT[int'(idx_s)*FLAG_W +: FLAG_W];
  end

endmodule

// File: rtl/cu_microseq.sv
// Microcode sequencer: fetches an instruction, then walks its micro-steps,
// handshaking with execution units and owning the PC and instruction register.
module cu_microseq
  import cu_pkg::*;
#(
  parameter int PC_W   = 23,
  parameter int IR_W   = 10,
  parameter int OP_W   = 8,
  parameter int STEP_W = 2,
  parameter int FLAG_W = 27,
  parameter logic [FLAG_W-1:0] FETCH_FLAGS = CU_FETCH_FLAGS,
  parameter logic [FLAG_W-1:0] WAIT_MASK   = CU_WAIT_MASK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IR_W-1:0]        irin,
  output logic [OP_W-1:0]        ir,
  output logic [IR_W+STEP_W-1:0] uaddr,
  input  logic [FLAG_W-1:0]      uword,
  output logic [FLAG_W-1:0]      flags_out,
  output logic [STEP_W-1:0]      step,
  output logic                   exec_start,
  input  logic                   exec_done,
  input  logic                   pcinflag,
  input  logic [PC_W-1:0]        pcin,
  output logic [PC_W-1:0]        pc,
  output logic                   write_en,
  output logic                   halted,
  input  logic                   resume
);

  cu_state_e         state_r, state_nx_s;
  logic [PC_W-1:0]   pc_r, pc_nx_s;
  logic [IR_W-1:0]   ir_r, ir_nx_s;
  logic [STEP_W-1:0] step_r, step_nx_s;
  logic              wait_s;
  logic              last_s;

  assign pc    = pc_r;
  assign ir    = ir_r[OP_W-1:0];
  assign step  = step_r;
  assign uaddr = {ir_r, step_r};

  // Next-state and output decode; outputs depend only on state and the ROM word
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    ir_nx_s    = ir_r;
    step_nx_s  = step_r;
    flags_out  = uword;
    exec_start = 1'b0;
    write_en   = 1'b0;
    halted     = 1'b0;
    wait_s     = |(uword & WAIT_MASK);
    // the last step index is forced terminal so step never wraps
    last_s     = uword[FLAG_END] || (&step_r);
    case (state_r)
      ST_FETCH: begin
        flags_out  = FETCH_FLAGS;
        ir_nx_s    = irin;
        pc_nx_s    = pc_r + PC_W'(1);
        step_nx_s  = {STEP_W{1'b0}};
        state_nx_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (uword[FLAG_PCC]) begin
          pc_nx_s = pc_r + PC_W'(1);
        end else begin
          pc_nx_s = pc_r;
        end
        if (wait_s) begin
          exec_start = 1'b1;
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_COMMIT;
        end
      end
      ST_WAIT: begin
        if (exec_done) begin
          state_nx_s = ST_COMMIT;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_COMMIT: begin
        write_en = 1'b1;
        if (pcinflag) begin
          pc_nx_s = pcin;
        end else begin
          pc_nx_s = pc_r;
        end
        if (last_s) begin
          if (uword[FLAG_HALT]) begin
            state_nx_s = ST_HALTED;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end else begin
          step_nx_s  = step_r + STEP_W'(1);
          state_nx_s = ST_ISSUE;
        end
      end
      ST_HALTED: begin
        flags_out = {FLAG_W{1'b0}};
        halted    = 1'b1;
        if (resume) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_HALTED;
        end
      end
      default: begin
        flags_out  = FETCH_FLAGS;
        state_nx_s = ST_FETCH;
      end
    endcase
  end

  // State, PC, instruction register and step index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= {PC_W{1'b0}};
      ir_r    <= {IR_W{1'b0}};
      step_r  <= {STEP_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      ir_r    <= ir_nx_s;
      step_r  <= step_nx_s;
    end
  end

endmodule
